// File: rtl/mest_pro_mem_arb.sv
// ---------------------------------------------------------------------------
// mest_pro_mem_arb
//
// Purpose:
//   Shares the single MESTPro memory port between instruction fetch and the
//   execute-stage load/store unit. Only one transaction is in flight at a
//   time. Requesters use req/gnt/valid, the memory side uses req/ack, and a
//   watchdog aborts a transaction that never sees an ack so the core
//   controller cannot deadlock.
//
// Configuration macro:
//   MEST_PRO_ARB_RR_EN  defined   -> round-robin between fetch and exec when
//                                    both request in the same IDLE cycle
//                       undefined -> fixed priority, exec beats fetch
//
// Ports:
//   clk            rising-edge clock
//   i_reset        asynchronous active-high reset
//   i_fetch_req    fetch request, held until o_fetch_gnt
//   i_fetch_addr   fetch address
//   o_fetch_gnt    1-cycle pulse, fetch accepted
//   o_fetch_valid  1-cycle pulse, fetch complete (o_fetch_rdata valid)
//   o_fetch_rdata  instruction word
//   i_exec_req     exec request, held until o_exec_gnt
//   i_exec_we      1 = store, 0 = load
//   i_exec_addr    load/store address
//   i_exec_wdata   store data
//   o_exec_gnt     1-cycle pulse, exec accepted
//   o_exec_valid   1-cycle pulse, load data valid / store done
//   o_exec_rdata   load data
//   o_mem_req      memory request, held until i_mem_ack
//   o_mem_we       memory write enable
//   o_mem_addr     memory address
//   o_mem_wdata    memory write data
//   i_mem_ack      memory completion (1 cycle)
//   i_mem_rdata    memory read data, valid with i_mem_ack
//   o_busy         transaction in flight
//   o_timeout      sticky: a transaction was aborted by the watchdog
// ---------------------------------------------------------------------------
module mest_pro_mem_arb #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    output logic              o_fetch_gnt,
    output logic              o_fetch_valid,
    output logic [DATA_W-1:0] o_fetch_rdata,
    input  logic              i_exec_req,
    input  logic              i_exec_we,
    input  logic [ADDR_W-1:0] i_exec_addr,
    input  logic [DATA_W-1:0] i_exec_wdata,
    output logic              o_exec_gnt,
    output logic              o_exec_valid,
    output logic [DATA_W-1:0] o_exec_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy,
    output logic              o_timeout
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MEM  = 1'b1;
    localparam int         TW     = $clog2(TIMEOUT + 1);

    logic [0:0]    r_state;
    logic          r_ownerExec;
    logic [TW-1:0] r_timer;
    logic          w_anyReq;
    logic          w_pickExec;
    logic          w_timerExpired;

    assign w_anyReq       = i_fetch_req | i_exec_req;
    // The counter holds the number of completed MEM cycles without an ack, so
    // the current cycle is the TIMEOUT-th one when it equals TIMEOUT-1.
    assign w_timerExpired = (r_timer == TW'(TIMEOUT - 1));

`ifdef MEST_PRO_ARB_RR_EN
    // r_lastExec remembers who owned the last granted transaction. Reset
    // value 0 means "fetch went last", so exec wins the first contest.
    logic r_lastExec;

    always_comb begin
        w_pickExec = i_exec_req;
        if (i_fetch_req && i_exec_req) begin
            w_pickExec = ~r_lastExec;
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_lastExec <= 1'b0;
        end else if (r_state == S_IDLE && w_anyReq) begin
            r_lastExec <= w_pickExec;
        end
    end
`else
    // Fixed priority: exec wins whenever it is requesting.
    assign w_pickExec = i_exec_req;
`endif

    // Main transaction FSM. Grants and valids are single-cycle pulses, so
    // they default to 0 each cycle and are only raised on the event edge.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_ownerExec   <= 1'b0;
            r_timer       <= '0;
            o_fetch_gnt   <= 1'b0;
            o_fetch_valid <= 1'b0;
            o_fetch_rdata <= '0;
            o_exec_gnt    <= 1'b0;
            o_exec_valid  <= 1'b0;
            o_exec_rdata  <= '0;
            o_mem_req     <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_wdata   <= '0;
            o_busy        <= 1'b0;
            o_timeout     <= 1'b0;
        end else begin
            o_fetch_gnt   <= 1'b0;
            o_exec_gnt    <= 1'b0;
            o_fetch_valid <= 1'b0;
            o_exec_valid  <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_anyReq) begin
                    r_state     <= S_MEM;
                    r_ownerExec <= w_pickExec;
                    r_timer     <= '0;
                    o_mem_req   <= 1'b1;
                    o_busy      <= 1'b1;
                    if (w_pickExec) begin
                        o_exec_gnt  <= 1'b1;
                        o_mem_we    <= i_exec_we;
                        o_mem_addr  <= i_exec_addr;
                        o_mem_wdata <= i_exec_wdata;
                    end else begin
                        o_fetch_gnt <= 1'b1;
                        o_mem_we    <= 1'b0;
                        o_mem_addr  <= i_fetch_addr;
                        o_mem_wdata <= '0;
                    end
                end
            end else begin
                // An ack on the last allowed cycle still counts as a normal
                // completion, so it is tested before the watchdog.
                if (i_mem_ack) begin
                    r_state   <= S_IDLE;
                    o_mem_req <= 1'b0;
                    o_busy    <= 1'b0;
                    if (r_ownerExec) begin
                        o_exec_valid <= 1'b1;
                        if (!o_mem_we) begin
                            o_exec_rdata <= i_mem_rdata;
                        end
                    end else begin
                        o_fetch_valid <= 1'b1;
                        o_fetch_rdata <= i_mem_rdata;
                    end
                end else if (w_timerExpired) begin
                    r_state   <= S_IDLE;
                    o_mem_req <= 1'b0;
                    o_busy    <= 1'b0;
                    o_timeout <= 1'b1;
                    if (r_ownerExec) begin
                        o_exec_valid <= 1'b1;
                        o_exec_rdata <= '0;
                    end else begin
                        o_fetch_valid <= 1'b1;
                        o_fetch_rdata <= '0;
                    end
                end else begin
                    r_timer <= r_timer + TW'(1);
                end
            end
        end
    end

endmodule
